audio_sample_buffer: RTL
========================

# audio_sample_buffer

Upstream feeder for the I2S `driver` stage.
- Takes the UART receiver's byte stream and assembles little-endian 16-bit mono samples.
- Stores the samples in an elastic FIFO and presents one sample on `mono_sample` per I2S frame.
- Paces readout with the driver's `sample_tick`, and pre-buffers before playback so UART jitter does not cause dropouts.

## Interface
- `DEPTH`, 1024: FIFO capacity in samples; power of two, ≥4.
- `START_LEVEL`, 512: fill level (samples) required to leave FILL; 1..DEPTH.
- `GAP_CYCLES`, 27000: idle clk cycles with no byte before the byte phase resets (1 ms at 27 MHz).
- `clk`, input, 1: system clock (27 MHz); also clocks the UART receiver.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: received byte.
- `rx_valid`, input, 1: one-clk strobe; `rx_data` is valid while it is high.
- `sample_tick`, input, 1: frame-end level from the driver; it is in the `bck` domain and is high for one `bck` period (≈18 clk).
- `clr`, input, 1: synchronous; clears the sticky flags and counters.
- `mono_sample`, output, 16: sample for the driver; registered.
- `playing`, output, 1: high in PLAY.
- `level`, output, clog2(DEPTH)+1: samples currently stored.
- `overrun`, output, 1: sticky; a sample was dropped because the FIFO was full.
- `underrun_cnt`, output, 16: saturating count of underruns.

## Operation
- Byte assembler, phases LO and HI:
  - LO: the byte is captured as `sample[7:0]`; phase goes to HI.
  - HI: the byte becomes `sample[15:8]`; a push is issued; phase goes to LO.
  - A gap counter reloads on every `rx_valid`. If it reaches GAP_CYCLES while in HI, the phase returns to LO and the pending low byte is discarded.
- FIFO:
  - Push on a completed sample. If `level`==DEPTH, the push is dropped and `overrun` is set. `level` and the data are unchanged.
  - Pointers are clog2(DEPTH) bits wide and wrap naturally. `level` = pushes − pops.
  - A simultaneous push and pop are both performed. `level` is unchanged; this is legal even when full, since the pop frees the slot first.
- Tick handling: `sample_tick` is passed through a 2-flop synchronizer followed by a rising-edge detect, giving `tick_p`, one clk wide.
- State machine, states FILL and PLAY:
  - FILL: `tick_p` causes no pop and forces `mono_sample`=0. Go to PLAY when `level` ≥ START_LEVEL.
  - PLAY: `tick_p` with `level`>0 pops one sample, which appears on `mono_sample`.
  - PLAY: `tick_p` with `level`==0 is an underrun. `mono_sample`=0, `underrun_cnt` increments (saturating at 0xFFFF), and the state returns to FILL.
- `mono_sample` holds its value between ticks.
- `clr` zeroes `overrun` and `underrun_cnt` only. FIFO contents and state are untouched.
- Reset values:
  - State: FILL; byte phase: LO; pointers and gap counter: 0; synchronizer flops: 0.
  - Outputs: `mono_sample`=0, `playing`=0, `level`=0, `overrun`=0, `underrun_cnt`=0.
- Reset asserted mid-stream flushes the FIFO; stale RAM contents are never output.

## Timing
- `sample_tick` rising edge → `tick_p`: 3 clk. `tick_p` → new `mono_sample`: 2 clk, because the RAM read is registered. Total ≤5 clk.
- The driver latches on the next `bck` rising edge (≈18 clk later). `mono_sample` is therefore stable ≥13 clk before it is latched.
- The FILL→PLAY transition takes effect 1 clk after `level` reaches START_LEVEL. The first pop happens on the next `tick_p`.
- Push: `level` increments 1 clk after the HI byte's `rx_valid`.
- Throughput: a push at most every 2 `rx_valid` strobes; a pop at most once per frame (≈612 clk).

## Structure
- Package `audio_stream_pkg` holds:
  - `SAMPLE_W`=16.
  - The state enum `{FILL, PLAY}`.
  - The default DEPTH, START_LEVEL and GAP_CYCLES constants, which the driver and UART top also import.
- Sub-module `sample_fifo_ram`: simple dual-port, one write port and one registered-read port, DEPTH×16. It infers Gowin BSRAM.
- Everything else (assembler, pointers, FSM, synchronizer) stays in `audio_sample_buffer`.

## Test plan
- Reset release, then bytes 0x34,0x12 → `level`=1 after 1 clk. With START_LEVEL=1, `playing`=1. The next tick gives `mono_sample`=0x1234 within 5 clk of the tick edge, then `level`=0.
- Push 512 samples (START_LEVEL=512) with ticks running → `mono_sample`=0 and no pops until the 512th push. `playing` rises 1 clk later, and samples then appear in order.
- Byte 0xAA, idle for GAP_CYCLES+1, then 0x01,0x00 → the stored sample is 0x0001; 0xAA is discarded.
- Fill to DEPTH, then one more sample → `overrun`=1 and `level`=DEPTH; that sample is never output. Then `clr` → `overrun`=0.
- In PLAY, drain to empty, then a tick → `mono_sample`=0, `underrun_cnt`=1, `playing`=0.
- Push and `tick_p` in the same clk at `level`=DEPTH → `level` stays DEPTH and there is no overrun. Also: `rst_n` pulsed low mid-frame → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/audio_stream_pkg.sv
// Shared constants and types for the audio streaming path.
// The I2S driver and the UART top import the default sizing from here as well.
package audio_stream_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int DEF_DEPTH       = 1024;
  localparam int DEF_START_LEVEL = 512;
  localparam int DEF_GAP_CYCLES  = 27000;  // 1 ms at 27 MHz

  typedef enum logic {
    FILL = 1'b0,
    PLAY = 1'b1
  } buf_state_e;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } byte_phase_e;

endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module sample_fifo_ram
  import audio_stream_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a read and a write to the same slot in one cycle return the old word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/audio_sample_buffer.sv
// Assembles UART bytes into 16-bit samples, buffers them in a FIFO and releases
// one sample per I2S frame, pre-filling before playback to ride out UART jitter.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | pre-buffering; frame ticks output 0, leave at level>=START
// PLAY  | each frame tick pops one sample; an empty FIFO -> underrun
module audio_sample_buffer
  import audio_stream_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int START_LEVEL = DEF_START_LEVEL,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   sample_tick,
  input  logic                   clr,
  output logic [SAMPLE_W-1:0]    mono_sample,
  output logic                   playing,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic [15:0]            underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  byte_phase_e         phase;
  logic [7:0]          lo_byte;
  logic [GW-1:0]       gap_cnt;
  logic                push_req;
  logic                push_ok;
  logic [SAMPLE_W-1:0] push_data;

  logic tick_s1, tick_s2, tick_s2_d, tick_p;

  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level_q;
  logic                full, empty;
  logic [SAMPLE_W-1:0] rd_data;

  buf_state_e state, state_nxt;
  logic       pop, underrun, zero_req;
  logic       pop_d, zero_d;

  assign push_req  = rx_valid && (phase == PH_HI);
  assign push_data = {rx_data, lo_byte};
  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push_ok   = push_req && (!full || pop);

  // Gap timer is a down-counter; expiry while waiting for the high byte drops the low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= PH_LO;
      lo_byte <= '0;
      gap_cnt <= '0;
    end else if (rx_valid) begin
      gap_cnt <= GW'(GAP_CYCLES);
      if (phase == PH_LO) begin
        lo_byte <= rx_data;
        phase   <= PH_HI;
      end else begin
        phase <= PH_LO;
      end
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
      if (gap_cnt == GW'(1)) phase <= PH_LO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_s2_d <= 1'b0;
      tick_p    <= 1'b0;
    end else begin
      tick_s1   <= sample_tick;
      tick_s2   <= tick_s1;
      tick_s2_d <= tick_s2;
      tick_p    <= tick_s2 && !tick_s2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  sample_fifo_ram #(
    .DEPTH(DEPTH),
    .WIDTH(SAMPLE_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr),
    .wr_data(push_data),
    .rd_en  (pop),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    underrun  = 1'b0;
    zero_req  = 1'b0;
    case (state)
      FILL: begin
        zero_req = tick_p;
        if (level_q >= LW'(START_LEVEL)) state_nxt = PLAY;
      end
      PLAY: begin
        if (tick_p) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            underrun  = 1'b1;
            zero_req  = 1'b1;
            state_nxt = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Output decision is delayed one cycle to line up with the registered RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_d       <= 1'b0;
      zero_d      <= 1'b0;
      mono_sample <= '0;
    end else begin
      pop_d  <= pop;
      zero_d <= zero_req;
      if (pop_d)       mono_sample <= rd_data;
      else if (zero_d) mono_sample <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun      <= 1'b0;
      underrun_cnt <= '0;
    end else if (clr) begin
      overrun      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (push_req && full && !pop) overrun <= 1'b1;
      if (underrun && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

  assign playing = (state == PLAY);
  assign level   = level_q;

endmodule
